// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_sequencer_pkg;

  localparam int unsigned LOSS_W = 8;

  typedef enum logic [4:0] {
    ST_HOLD      = 5'b00001,
    ST_WAIT_LOCK = 5'b00010,
    ST_STABLE    = 5'b00100,
    ST_RUN       = 5'b01000,
    ST_FAIL      = 5'b10000
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL power-up/recovery sequencer: holds PLL reset, qualifies lock, releases
// the system reset after a stable window, retries on timeout and latches failure.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES          = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 74250,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 17,
  parameter int unsigned RETRY_W             = 2
) (
  input  logic               clk_74a,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               restart_req,
  output logic               pll_rst,
  output logic               sys_reset_n,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  lock_loss_cnt
);

  localparam logic [CNT_W-1:0]   L_RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   L_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   L_TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] L_MAX_RETRY   = RETRY_W'(MAX_RETRIES);

  logic               w_lock_s;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic [LOSS_W-1:0]  r_loss;
  logic               w_loss_inc;
  logic               r_pll_rst;
  logic               r_sys_rst_n;
  logic               r_ready;
  logic               r_fail;

  sync_2ff u_lock_sync (
    .i_clk   (clk_74a),
    .i_rst_n (reset_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  // Priority: restart_req, then lock change, then counter expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_loss_inc  = 1'b0;
    if (restart_req) begin
      w_state_nxt = ST_HOLD;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_HOLD: if (r_cnt == L_RST_LAST) w_state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nxt = ST_STABLE;
          end else if (r_cnt == L_TO_LAST) begin
            if (r_retry < L_MAX_RETRY) begin
              w_retry_nxt = r_retry + 1'b1;
              w_state_nxt = ST_HOLD;
            end else begin
              w_state_nxt = ST_FAIL;
            end
          end
        end
        ST_STABLE: begin
          if (!w_lock_s)                  w_state_nxt = ST_WAIT_LOCK;
          else if (r_cnt == L_STABLE_LAST) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            w_state_nxt = ST_HOLD;
            w_retry_nxt = '0;
            w_loss_inc  = 1'b1;
          end
        end
        ST_FAIL: w_state_nxt = ST_FAIL;
        default: w_state_nxt = ST_HOLD;
      endcase
    end
    w_cnt_nxt = (restart_req || (w_state_nxt != r_state) || (r_state inside {ST_RUN, ST_FAIL}))
                ? '0 : r_cnt + 1'b1;
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_HOLD;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_loss      <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      if (w_loss_inc && (r_loss != '1)) r_loss <= r_loss + 1'b1;
      r_pll_rst   <= (w_state_nxt == ST_HOLD);
      r_sys_rst_n <= (w_state_nxt == ST_RUN);
      r_ready     <= (w_state_nxt == ST_RUN);
      r_fail      <= (w_state_nxt == ST_FAIL);
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_reset_n   = r_sys_rst_n;
  assign ready         = r_ready;
  assign fail          = r_fail;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_loss;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expectations are queued with a due
// edge when stimulus is applied and compared on the falling edge after it.
module tb_pll_reset_sequencer;
  import pll_reset_sequencer_pkg::*;

  localparam int unsigned RST = 4;
  localparam int unsigned STB = 8;
  localparam int unsigned TO  = 32;
  localparam int unsigned MR  = 2;

  logic       clk_74a     = 1'b0;
  logic       reset_n     = 1'b0;
  logic       pll_locked  = 1'b0;
  logic       restart_req = 1'b0;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int loss_exp = 0;

  typedef struct {
    string       tag;
    int          due;
    logic [13:0] exp;
  } exp_t;
  exp_t sb[$];

  pll_reset_sequencer #(
    .RST_CYCLES          (RST),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MR),
    .CNT_W               (clog2(TO)),
    .RETRY_W             (2)
  ) dut (
    .clk_74a       (clk_74a),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .restart_req   (restart_req),
    .pll_rst       (pll_rst),
    .sys_reset_n   (sys_reset_n),
    .ready         (ready),
    .fail          (fail),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk_74a = ~clk_74a;
  always @(posedge clk_74a) cyc <= cyc + 1;

  // Vector order: pll_rst, sys_reset_n, ready, fail, retry_cnt[1:0], lock_loss_cnt[7:0]
  function automatic logic [13:0] mk(input bit pr, input bit srn, input bit rdy, input bit fl,
                                     input int rc, input int llc);
    return {pr, srn, rdy, fl, 2'(rc), 8'(llc)};
  endfunction

  function automatic logic [13:0] obs();
    return {pll_rst, sys_reset_n, ready, fail, retry_cnt, lock_loss_cnt};
  endfunction

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s @edge %0d: got=%b want=%b", tag, cyc, got, want);
    end
  endtask

  task automatic expect_in(input int n, input string tag, input logic [13:0] v);
    sb.push_back('{tag, cyc + n, v});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_74a);
      #1;
    end
  endtask

  always @(negedge clk_74a) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, obs(), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic lose_and_recover();
    int prev;
    prev       = loss_exp;
    loss_exp   = (loss_exp < 255) ? loss_exp + 1 : 255;
    pll_locked = 1'b0;
    expect_in(2,  "loss_still_run", mk(0, 1, 1, 0, 0, prev));
    expect_in(3,  "loss_hold",      mk(1, 0, 0, 0, 0, loss_exp));
    step(3);
    pll_locked = 1'b1;
    expect_in(12, "loss_pre_run",   mk(0, 0, 0, 0, 0, loss_exp));
    expect_in(13, "loss_recover",   mk(0, 1, 1, 0, 0, loss_exp));
    step(13);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up with normal lock
    step(3);
    check("reset_vals", obs(), mk(1, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    expect_in(3, "hold_last", mk(1, 0, 0, 0, 0, 0));
    expect_in(4, "hold_end",  mk(0, 0, 0, 0, 0, 0));
    step(5);
    pll_locked = 1'b1;
    expect_in(10, "pre_release", mk(0, 0, 0, 0, 0, 0));
    expect_in(11, "release",     mk(0, 1, 1, 0, 0, 0));
    step(14);

    // Single lock loss in RUN
    lose_and_recover();

    // Restart coincident with a lock drop seen by the FSM
    pll_locked = 1'b0;
    expect_in(2, "co_still_run", mk(0, 1, 1, 0, 0, loss_exp));
    step(2);
    restart_req = 1'b1;
    expect_in(1, "co_restart", mk(1, 0, 0, 0, 0, loss_exp));
    step(1);
    restart_req = 1'b0;
    pll_locked  = 1'b1;
    expect_in(13, "co_recover", mk(0, 1, 1, 0, 0, loss_exp));
    step(14);

    // Restart from RUN, then a one-cycle lock glitch at STABLE cnt=5
    restart_req = 1'b1;
    expect_in(1, "restart_from_run", mk(1, 0, 0, 0, 0, loss_exp));
    step(1);
    restart_req = 1'b0;
    expect_in(11, "glitch_no_hold_a", mk(0, 0, 0, 0, 0, loss_exp));
    expect_in(12, "glitch_no_hold_b", mk(0, 0, 0, 0, 0, loss_exp));
    expect_in(13, "glitch_no_early",  mk(0, 0, 0, 0, 0, loss_exp));
    expect_in(19, "glitch_pre_run",   mk(0, 0, 0, 0, 0, loss_exp));
    expect_in(20, "glitch_release",   mk(0, 1, 1, 0, 0, loss_exp));
    step(8);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(12);

    // Saturate the lock-loss counter (300 losses in total)
    repeat (299) lose_and_recover();
    check("loss_saturated", obs(), mk(0, 1, 1, 0, 0, 255));

    // Asynchronous reset in STABLE, between clock edges
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    step(7);
    check("pre_async_stable", obs(), mk(0, 0, 0, 0, 0, 255));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", obs(), mk(1, 0, 0, 0, 0, 0));
    loss_exp   = 0;
    pll_locked = 1'b0;
    step(2);

    // Lock never asserts: two retries, then FAIL
    reset_n = 1'b1;
    expect_in(3,   "nl_hold0_last", mk(1, 0, 0, 0, 0, 0));
    expect_in(4,   "nl_wait0",      mk(0, 0, 0, 0, 0, 0));
    expect_in(35,  "nl_wait0_last", mk(0, 0, 0, 0, 0, 0));
    expect_in(36,  "nl_hold1",      mk(1, 0, 0, 0, 1, 0));
    expect_in(39,  "nl_hold1_last", mk(1, 0, 0, 0, 1, 0));
    expect_in(40,  "nl_wait1",      mk(0, 0, 0, 0, 1, 0));
    expect_in(71,  "nl_wait1_last", mk(0, 0, 0, 0, 1, 0));
    expect_in(72,  "nl_hold2",      mk(1, 0, 0, 0, 2, 0));
    expect_in(76,  "nl_wait2",      mk(0, 0, 0, 0, 2, 0));
    expect_in(107, "nl_wait2_last", mk(0, 0, 0, 0, 2, 0));
    expect_in(108, "nl_fail",       mk(0, 0, 0, 1, 2, 0));
    expect_in(250, "nl_fail_held",  mk(0, 0, 0, 1, 2, 0));
    step(252);

    // Restart out of FAIL with lock present
    restart_req = 1'b1;
    pll_locked  = 1'b1;
    expect_in(1,  "fail_restart",  mk(1, 0, 0, 0, 0, 0));
    expect_in(13, "post_fail_pre", mk(0, 0, 0, 0, 0, 0));
    expect_in(14, "post_fail_run", mk(0, 1, 1, 0, 0, 0));
    step(1);
    restart_req = 1'b0;
    step(16);

    check("scoreboard_drained", 14'(sb.size()), 14'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
